// File: rtl/shift_unit.sv
// -----------------------------------------------------------------------------
// shift_unit
//   Multi-cycle shifter that produces the barrel_out operand for the 16-bit ULA
//   (OPcode 2'b11 path). A start request in IDLE captures an operand, a shift
//   amount and a shift type. The operand is then shifted one bit position per
//   clock. The result is presented on a registered output together with a
//   one-cycle done pulse.
//
//   Optional feature: define SHIFT_STEP4_EN to shift four positions per clock
//   while at least four positions remain. Results are identical to the 1-bit
//   build; only the latency changes.
//
// Ports
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   start      in   1      request; accepted only in IDLE when done is low
//   data_in    in   WIDTH  operand, captured on an accepted start
//   shamt      in   AMT_W  shift amount, captured on an accepted start
//   sh_op      in   2      00 LSL, 01 LSR, 10 ASR, 11 ROR
//   busy       out  1      high whenever the FSM is not in IDLE
//   done       out  1      one-cycle pulse; shift_out is valid from this cycle
//   shift_out  out  WIDTH  result register; holds between operations
// -----------------------------------------------------------------------------
module shift_unit #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] shamt,
  input  logic [1:0]       sh_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shift_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] shift_out_q, shift_out_d;
  logic             done_q, done_d;
  logic             accept;

  // Single-position shift for the given operation.
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] w,
                                             input logic [1:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      OP_LSL:  r = {w[WIDTH-2:0], 1'b0};
      OP_LSR:  r = {1'b0, w[WIDTH-1:1]};
      OP_ASR:  r = {w[WIDTH-1], w[WIDTH-1:1]};
      default: r = {w[0], w[WIDTH-1:1]};
    endcase
    return r;
  endfunction

`ifdef SHIFT_STEP4_EN
  // Four-position shift; equivalent to four consecutive step1 calls.
  function automatic logic [WIDTH-1:0] step4(input logic [WIDTH-1:0] w,
                                             input logic [1:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      OP_LSL:  r = {w[WIDTH-5:0], 4'b0000};
      OP_LSR:  r = {4'b0000, w[WIDTH-1:4]};
      OP_ASR:  r = {{4{w[WIDTH-1]}}, w[WIDTH-1:4]};
      default: r = {w[3:0], w[WIDTH-1:4]};
    endcase
    return r;
  endfunction
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q      <= '0;
      count_q     <= '0;
      op_q        <= '0;
      shift_out_q <= '0;
      done_q      <= 1'b0;
    end else begin
      work_q      <= work_d;
      count_q     <= count_d;
      op_q        <= op_d;
      shift_out_q <= shift_out_d;
      done_q      <= done_d;
    end
  end

  // A start in the same cycle as the done pulse is dropped, so the next
  // request is taken only once the unit is idle with done low.
  assign accept = (state_q == S_IDLE) && start && !done_q;

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    count_d     = count_q;
    op_d        = op_q;
    shift_out_d = shift_out_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          work_d  = data_in;
          count_d = shamt;
          op_d    = sh_op;
          state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
`ifdef SHIFT_STEP4_EN
        if (count_q >= AMT_W'(4)) begin
          work_d  = step4(work_q, op_q);
          count_d = count_q - AMT_W'(4);
        end else begin
          work_d  = step1(work_q, op_q);
          count_d = count_q - AMT_W'(1);
        end
`else
        work_d  = step1(work_q, op_q);
        count_d = count_q - AMT_W'(1);
`endif
        if (count_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Result register only ever changes here, so the ULA operand is
        // stable between operations.
        shift_out_d = work_q;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = done_q;
    shift_out = shift_out_q;
  end

endmodule
